ntt_index_sequencer: RTL and testbench

Sequencer that produces the (p, k, j) loop-index stream driving the radix-4, two-butterfly-per-cycle NTT address generator: one index triple per accepted cycle, 128 triples per stage, 5 stages for N = 1024. It sits directly upstream of the address generator and is started by the NTT top-level control. It owns stage ordering (forward or inverse), valid/ready flow control toward the memory/BFU datapath, and a programmable pipeline-drain gap between stages.

---
 rtl/ntt_index_sequencer.sv | 169 ++++++++++++++++
 tb/tb_ntt_index_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_index_sequencer.sv
// ntt_index_sequencer
// Generates the (p, k, j) loop-index stream for a radix-4, two-butterfly-per-cycle
// NTT address generator (N = 1024: 5 stages x 128 triples). Handles forward or
// inverse stage order, valid/ready flow control and a fixed pipeline-drain gap
// between stages. All outputs are registered from the next-state values.
module ntt_index_sequencer #(
  parameter int DRAIN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       inv_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [6:0] k_o,
  output logic [7:0] j_o,
  output logic [2:0] p_o,
  output logic       last_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Terminal value of the drain counter; only meaningful when a gap is configured.
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  localparam bit         DRAIN_EN   = (DRAIN_CYCLES != 0);

  state_t     state_r, state_s;
  logic [2:0] p_r, p_s;
  logic [6:0] c_r, c_s;
  logic       inv_r, inv_s;
  logic [7:0] drain_r, drain_s;
  logic       accept_s;
  logic       final_stage_s;

  logic        valid_s;
  logic        busy_s;
  logic        done_s;
  logic        last_s;
  logic [14:0] idx_s;

  // Map (stage, counter) to {k, j}: with s = 2p-1 the low s bits of c form the
  // intra-group offset (doubled, so j is always even) and the high bits form k.
  function automatic logic [14:0] index_of(input logic [2:0] p, input logic [6:0] c);
    logic [6:0] k;
    logic [7:0] j;
    case (p)
      3'd0: begin k = c;                  j = 8'd0;                 end
      3'd1: begin k = {1'b0, c[6:1]};     j = {6'd0, c[0], 1'b0};   end
      3'd2: begin k = {3'd0, c[6:3]};     j = {4'd0, c[2:0], 1'b0}; end
      3'd3: begin k = {5'd0, c[6:5]};     j = {2'd0, c[4:0], 1'b0}; end
      3'd4: begin k = 7'd0;               j = {c[6:0], 1'b0};       end
      default: begin k = 7'd0;            j = 8'd0;                 end
    endcase
    return {k, j};
  endfunction

  // State register: FSM state, stage/counter position, latched direction, drain count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      p_r     <= 3'd0;
      c_r     <= 7'd0;
      inv_r   <= 1'b0;
      drain_r <= 8'd0;
    end else begin
      state_r <= state_s;
      p_r     <= p_s;
      c_r     <= c_s;
      inv_r   <= inv_s;
      drain_r <= drain_s;
    end
  end

  // Next-state logic: advance on each accepted triple, step stages, insert drain gaps.
  always_comb begin
    state_s       = state_r;
    p_s           = p_r;
    c_s           = c_r;
    inv_s         = inv_r;
    drain_s       = drain_r;
    accept_s      = (state_r == ST_RUN) && ready_i;
    final_stage_s = inv_r ? (p_r == 3'd0) : (p_r == 3'd4);
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s = ST_RUN;
          inv_s   = inv_i;
          p_s     = inv_i ? 3'd4 : 3'd0;
          c_s     = 7'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!accept_s) begin
          state_s = ST_RUN;
        end else if (c_r != 7'd127) begin
          c_s = c_r + 7'd1;
        end else if (final_stage_s) begin
          state_s = ST_DONE;
        end else begin
          p_s = inv_r ? (p_r - 3'd1) : (p_r + 3'd1);
          c_s = 7'd0;
          if (DRAIN_EN) begin
            state_s = ST_DRAIN;
            drain_s = 8'd0;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_s = ST_RUN;
          drain_s = 8'd0;
        end else begin
          drain_s = drain_r + 8'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        c_s     = 7'd0;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output can be registered.
  always_comb begin
    valid_s = (state_s == ST_RUN);
    busy_s  = (state_s == ST_RUN) || (state_s == ST_DRAIN);
    done_s  = (state_s == ST_DONE);
    last_s  = (state_s == ST_RUN) && (c_s == 7'd127);
    idx_s   = index_of(p_s, c_s);
  end

  // Output register: indices update only with a valid triple and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      last_o  <= 1'b0;
      k_o     <= 7'd0;
      j_o     <= 8'd0;
      p_o     <= 3'd0;
    end else begin
      valid_o <= valid_s;
      busy_o  <= busy_s;
      done_o  <= done_s;
      last_o  <= last_s;
      if (valid_s) begin
        k_o <= idx_s[14:8];
        j_o <= idx_s[7:0];
        p_o <= p_s;
      end
    end
  end

endmodule

// File: tb/tb_ntt_index_sequencer.sv
// Testbench for ntt_index_sequencer: two instances (drain gap 8 and 0) share
// ready/inv stimulus; expected triples from the index formula go into
// per-instance queues, and negedge monitors pop and compare on each acceptance.
module tb_ntt_index_sequencer;

  localparam int DR = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start0 = 1'b0;
  logic       inv = 1'b0;
  logic       ready = 1'b1;

  logic       v8, l8, b8, d8, v0, l0, b0, d0;
  logic [6:0] k8, k0;
  logic [7:0] j8, j0;
  logic [2:0] p8, p0;

  ntt_index_sequencer #(.DRAIN_CYCLES(DR)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .inv_i(inv), .ready_i(ready),
    .valid_o(v8), .k_o(k8), .j_o(j8), .p_o(p8), .last_o(l8), .busy_o(b8), .done_o(d8)
  );

  ntt_index_sequencer #(.DRAIN_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .inv_i(inv), .ready_i(ready),
    .valid_o(v0), .k_o(k0), .j_o(j0), .p_o(p0), .last_o(l0), .busy_o(b0), .done_o(d0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] p;
    logic [6:0] k;
    logic [7:0] j;
    logic       last;
  } trip_t;

  trip_t q8[$];
  trip_t q0[$];
  int    checks = 0;
  int    errors = 0;
  int    dones8 = 0, dones0 = 0;
  int    gap8 = 0;
  bit    stall8 = 1'b0, stall0 = 1'b0;
  trip_t held8, held0;

  // Reference model: whole transform from the stage formula s = 2p-1.
  function automatic void push_run(input bit invb);
    for (int si = 0; si < 5; si++) begin
      int p;
      p = invb ? (4 - si) : si;
      for (int c = 0; c < 128; c++) begin
        trip_t t;
        t.p = 3'(p);
        if (p == 0) begin
          t.k = 7'(c);
          t.j = 8'd0;
        end else begin
          int s;
          s = 2 * p - 1;
          t.k = 7'(c >> s);
          t.j = 8'((c % (1 << s)) * 2);
        end
        t.last = (c == 127);
        q8.push_back(t);
        q0.push_back(t);
      end
    end
  endfunction

  // Monitor for the drain-8 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall8 = 1'b0;
      gap8   = 0;
    end else begin
      trip_t got, exp;
      got = {p8, k8, j8, l8};
      if (stall8) begin
        checks++;
        if (!v8 || got != held8) begin
          errors++;
          $display("FAIL stall8 got v=%0d %h exp v=1 %h", v8, got, held8);
        end
      end
      if (v8 && ready) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL extra8 got p=%0d k=%0d j=%0d exp none", p8, k8, j8);
        end else begin
          exp = q8.pop_front();
          if (got != exp) begin
            errors++;
            $display("FAIL triple8 got p=%0d k=%0d j=%0d last=%0d exp p=%0d k=%0d j=%0d last=%0d",
                     p8, k8, j8, l8, exp.p, exp.k, exp.j, exp.last);
          end
        end
      end
      stall8 = v8 && !ready;
      held8  = got;
      if (b8 && !v8) begin
        gap8++;
      end else if (v8 && gap8 != 0) begin
        checks++;
        if (gap8 != DR) begin
          errors++;
          $display("FAIL gap8 got %0d exp %0d", gap8, DR);
        end
        gap8 = 0;
      end
      if (d8) begin
        dones8++;
        checks++;
        if (q8.size() != 0 || v8 || b8) begin
          errors++;
          $display("FAIL done8 got left=%0d v=%0d b=%0d exp 0 0 0", q8.size(), v8, b8);
        end
      end
    end
  end

  // Monitor for the zero-drain instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall0 = 1'b0;
    end else begin
      trip_t got, exp;
      got = {p0, k0, j0, l0};
      if (stall0) begin
        checks++;
        if (!v0 || got != held0) begin
          errors++;
          $display("FAIL stall0 got v=%0d %h exp v=1 %h", v0, got, held0);
        end
      end
      if (b0) begin
        checks++;
        if (!v0) begin
          errors++;
          $display("FAIL nogap0 got valid=0 exp 1 at cycle %0d", cyc);
        end
      end
      if (v0 && ready) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL extra0 got p=%0d k=%0d j=%0d exp none", p0, k0, j0);
        end else begin
          exp = q0.pop_front();
          if (got != exp) begin
            errors++;
            $display("FAIL triple0 got p=%0d k=%0d j=%0d last=%0d exp p=%0d k=%0d j=%0d last=%0d",
                     p0, k0, j0, l0, exp.p, exp.k, exp.j, exp.last);
          end
        end
      end
      stall0 = v0 && !ready;
      held0  = got;
      if (d0) begin
        dones0++;
        checks++;
        if (q0.size() != 0 || v0 || b0) begin
          errors++;
          $display("FAIL done0 got left=%0d v=%0d b=%0d exp 0 0 0", q0.size(), v0, b0);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if ({v8, l8, b8, d8, k8, j8, p8, v0, l0, b0, d0, k0, j0, p0} != '0) begin
      errors++;
      $display("FAIL %s got v=%0d b=%0d d=%0d l=%0d p=%0d k=%0d j=%0d / v=%0d b=%0d d=%0d p=%0d exp all 0",
               name, v8, b8, d8, l8, p8, k8, j8, v0, b0, d0, p0);
    end
  endtask

  // Full transform on both instances; abort_at >= 0 asserts reset after that many cycles.
  task automatic run(input bit invb, input bit rnd, input int abort_at);
    int n, sc, at8, at0, e8, e0;
    bit f8, f0;
    e8 = dones8 + 1;
    e0 = dones0 + 1;
    push_run(invb);
    @(posedge clk); #1;
    inv = invb; start8 = 1'b1; start0 = 1'b1;
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    sc = cyc; inv = ~invb; start8 = 1'b0; start0 = 1'b0;
    n = 0; f8 = 1'b0; f0 = 1'b0; at8 = 0; at0 = 0;
    while (!(f8 && f0) && n < 4000) begin
      if (abort_at == n) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        q8.delete();
        q0.delete();
        @(negedge clk); @(negedge clk);
        check_zero("abort_hold");
        rst_n = 1'b1;
        start8 = 1'b0; start0 = 1'b0;
        @(posedge clk); #1;
        break;
      end
      if (rnd) ready = 1'($urandom_range(0, 1));
      start8 = d8;
      start0 = d0;
      if (n == 200) begin start8 = 1'b1; start0 = 1'b1; end
      if (d8 && !f8) begin f8 = 1'b1; at8 = cyc - sc; end
      if (d0 && !f0) begin f0 = 1'b1; at0 = cyc - sc; end
      @(posedge clk); #1;
      n++;
    end
    start8 = 1'b0; start0 = 1'b0; ready = 1'b1;
    if (abort_at >= 0) begin
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dones8 != e8 - 1 || dones0 != e0 - 1 || b8 || b0) begin
        errors++;
        $display("FAIL abort_done got d8=%0d d0=%0d b8=%0d b0=%0d exp %0d %0d 0 0",
                 dones8, dones0, b8, b0, e8 - 1, e0 - 1);
      end
    end else begin
      checks++;
      if (n >= 4000) begin
        errors++;
        $display("FAIL timeout got f8=%0d f0=%0d exp 1 1", f8, f0);
      end
      if (!rnd) begin
        checks++;
        if (at8 != 640 + 4 * DR || at0 != 640) begin
          errors++;
          $display("FAIL latency got %0d/%0d exp %0d/640", at8, at0, 640 + 4 * DR);
        end
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (b8 || b0 || v8 || v0 || dones8 != e8 || dones0 != e0 || q8.size() != 0 || q0.size() != 0) begin
        errors++;
        $display("FAIL end_state got b=%0d/%0d v=%0d/%0d dones=%0d/%0d left=%0d/%0d exp 0 0 %0d/%0d 0/0",
                 b8, b0, v8, v0, dones8, dones0, q8.size(), q0.size(), e8, e0);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("idle");
    run(1'b0, 1'b0, -1);
    run(1'b1, 1'b0, -1);
    run(1'b0, 1'b1, -1);
    run(1'b1, 1'b1, -1);
    run(1'b0, 1'b0, 300);
    run(1'b0, 1'b0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
